// File: rtl/flags_pkg.sv
// flags_pkg: shared definitions for the condition-flag register.
//   F_N/F_Z/F_C/F_V : bit positions of each flag inside flags_t
//   COND_*          : branch-condition select codes
//   flags_t         : packed {N,Z,C,V} flag set
//   eval_cond       : evaluates a condition code against a flag set
package flags_pkg;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_N      = 3'b011;
  localparam logic [2:0] COND_NN     = 3'b100;
  localparam logic [2:0] COND_C      = 3'b101;
  localparam logic [2:0] COND_V      = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  typedef logic [3:0] flags_t;

  function automatic logic eval_cond(input flags_t f, input logic [2:0] c);
    logic r;
    case (c)
      COND_ALWAYS: r = 1'b1;
      COND_Z:      r = f[F_Z];
      COND_NZ:     r = ~f[F_Z];
      COND_N:      r = f[F_N];
      COND_NN:     r = ~f[F_N];
      COND_C:      r = f[F_C];
      COND_V:      r = f[F_V];
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// flag_stack: DEPTH-entry LIFO of flags_t for saving/restoring the flag set.
//   ck, Reset : clock and synchronous active-high reset
//   push, pop : stack requests (both together is an illegal no-op)
//   wr_flags  : value saved on a legal push
//   rd_flags  : top-of-stack entry (entry depth-1), valid when not empty
//   pop_ok    : high when this cycle's pop is legal and will take effect
//   depth     : occupied entries; full/empty derived from it
//   err       : sticky, set by push-when-full, pop-when-empty or push+pop
module flag_stack
  import flags_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       Reset,
  input  logic                       push,
  input  logic                       pop,
  input  flags_t                     wr_flags,
  output flags_t                     rd_flags,
  output logic                       pop_ok,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int DW = $clog2(DEPTH+1);

  logic [DW-1:0] depth_reg;
  logic          err_reg;
  logic          push_ok;
  logic          illegal;
  flags_t        mem [DEPTH];

  assign full    = (depth_reg == DW'(DEPTH));
  assign empty   = (depth_reg == '0);
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign illegal = (push & pop) | (push & full) | (pop & empty);

  always_ff @(posedge ck) begin
    if (Reset) begin
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (push_ok)
        depth_reg <= depth_reg + 1'b1;
      else if (pop_ok)
        depth_reg <= depth_reg - 1'b1;
      if (illegal)
        err_reg <= 1'b1;
    end
  end

  // Entries are not reset: depth alone defines which ones are meaningful.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge ck) begin
      if (!Reset && push_ok && depth_reg == DW'(gi))
        mem[gi] <= wr_flags;
    end
  end

  // Top-of-stack read is combinational so a pop restores the flags on the
  // same edge it decrements depth; it only feeds the flag register input.
  always_comb begin
    rd_flags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_reg == DW'(i + 1))
        rd_flags = mem[i];
    end
  end

  assign depth = depth_reg;
  assign err   = err_reg;

endmodule

// File: rtl/reg_flags.sv
// reg_flags: N/Z/C/V condition-flag register with per-flag load enables,
// branch-condition evaluation and a save/restore LIFO.
//   ck, Reset        : clock and synchronous active-high reset
//   result           : ALU result (N = MSB, Z = all zero)
//   c_in, v_in       : carry and overflow from the ALU
//   load_mask        : per-flag load enable {N,Z,C,V}
//   push, pop        : save / restore the flag set
//   cond             : branch-condition select
//   sN, sZ, sC, sV   : registered flags
//   cond_true        : selected condition on the registered flags
//   depth, stack_full, stack_empty, stack_err : stack status
module reg_flags
  import flags_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           result,
  input  logic                       c_in,
  input  logic                       v_in,
  input  logic [3:0]                 load_mask,
  input  logic                       push,
  input  logic                       pop,
  input  logic [2:0]                 cond,
  output logic                       sN,
  output logic                       sZ,
  output logic                       sC,
  output logic                       sV,
  output logic                       cond_true,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err
);

  flags_t flags_reg;
  flags_t flags_next;
  flags_t derived;
  flags_t stack_rd;
  logic   pop_ok;

  always_comb begin
    derived      = '0;
    derived[F_N] = result[WIDTH-1];
    derived[F_Z] = (result == '0);
    derived[F_C] = c_in;
    derived[F_V] = v_in;
  end

  // A legal pop overrides the load mask entirely; otherwise each flag is
  // loaded independently (illegal stack operations still allow the load).
  always_comb begin
    flags_next = flags_reg;
    if (pop_ok) begin
      flags_next = stack_rd;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_mask[i])
          flags_next[i] = derived[i];
      end
    end
  end

  always_ff @(posedge ck) begin
    if (Reset)
      flags_reg <= '0;
    else
      flags_reg <= flags_next;
  end

  // The stack saves the pre-edge flags, so a push with a simultaneous load
  // stores the old set while the register takes the new one.
  flag_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .ck       (ck),
    .Reset    (Reset),
    .push     (push),
    .pop      (pop),
    .wr_flags (flags_reg),
    .rd_flags (stack_rd),
    .pop_ok   (pop_ok),
    .depth    (depth),
    .full     (stack_full),
    .empty    (stack_empty),
    .err      (stack_err)
  );

  assign sN        = flags_reg[F_N];
  assign sZ        = flags_reg[F_Z];
  assign sC        = flags_reg[F_C];
  assign sV        = flags_reg[F_V];
  assign cond_true = eval_cond(flags_reg, cond);

endmodule
